muldiv_iter: RTL
================

# muldiv_iter

Iterative, parametrised multiply/divide unit for the EX stage. It replaces single-shot mult/div helpers with one shared shift-add / restoring-divide datapath, with an explicit start/done handshake, pipeline stall request, flush, and signed/unsigned modes. It produces a double-width result split into HI and LO, which feeds the HILO write port.

## Interface
- `DATA_WIDTH`, default 32: operand width W; HI and LO are each W bits wide. Must be ≥4 and even.
- `CNT_WIDTH`, default 6: iteration counter width; must satisfy 2^CNT_WIDTH > W.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op` in 2: operation select. 00 = MULTU, 01 = MULT (signed), 10 = DIVU, 11 = DIV (signed).
- `operand_1` in W: multiplicand or dividend.
- `operand_2` in W: multiplier or divisor.
- `flush` in 1: abort the operation in flight.
- `stall_request` out 1: hold the pipeline while the operation is unfinished.
- `busy` out 1: high in CALC and FIX.
- `done` out 1: one-cycle pulse; HI/LO are valid when it is high.
- `hi_result` out W: product[2W-1:W], or the remainder.
- `lo_result` out W: product[W-1:0], or the quotient.
- `div_by_zero` out 1: high together with `done` when a divide had operand_2 = 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC when `start`=1 and `flush`=0.
  - Latch the operation and the absolute values of the operands. Absolute values apply to the signed ops only.
  - Latch the result signs: for MULT, sign = s1^s2. For DIV, quotient sign = s1^s2 and remainder sign = s1.
  - Clear the counter.
- CALC runs one iteration per cycle for exactly W cycles, then goes to FIX.
  - Multiply: 2W-bit accumulator. The multiplier shifts right; if its LSB is 1, the multiplicand is added to the upper half, then the accumulator shifts right.
  - Divide: restoring. Shift {rem,quo} left by 1, trial-subtract the divisor from rem. If the difference is ≥ 0, keep it and set the quotient LSB to 1.
- FIX (1 cycle): apply two's-complement sign correction to the result, then go to DONE.
- DONE (1 cycle): `done`=1; load `hi_result`/`lo_result`; then go to IDLE.
- HI/LO hold their value until the next DONE. They are never disturbed by flush or by a new start.
- Divide by zero: quotient = all ones, remainder = operand_1 unmodified (the sign fix is not applied to either), `div_by_zero`=1 during `done`.
- Overflow on signed DIV (most-negative ÷ -1): quotient = most-negative value, remainder = 0, no flag.
- Signed MULT of most-negative × most-negative: the full 2W-bit result is exact. Absolute values are held as W-bit unsigned magnitudes.
- `start` outside IDLE is ignored. No queueing.
- `flush` in any state → IDLE next edge.
  - A flush in DONE still lets that cycle's `done` pulse through, because it is already asserted.
  - A flush together with `start` in IDLE wins: no operation is launched.
- `stall_request` = (IDLE & `start` & ~`flush`) | CALC | FIX. It is low in DONE, so the consuming instruction advances in the same cycle `done` is seen.

## Timing
- Reset values: state = IDLE; `busy`, `done`, `stall_request` (registered part), `div_by_zero` = 0; `hi_result` = `lo_result` = 0.
- Reset in mid-operation discards the operation and leaves HI/LO at 0.
- Latency with `start` sampled at edge 0:
  - CALC occupies edges 1..W.
  - FIX is the cycle after edge W.
  - `done`=1 in the cycle following edge W+1.
  - The total is W+2 cycles (34 for W=32).
- Throughput: the next start is accepted in the cycle after DONE, so back-to-back operations are W+3 cycles apart.
- `stall_request` is combinational from `start` in IDLE and registered otherwise.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: a multiply leaves CALC early when the remaining multiplier bits are all zero.
  - The accumulator is aligned by a final shift in FIX.
  - Latency is then (index of the highest set bit of |operand_2|) + 3 cycles, with a minimum of 3.
  - A multiply by 0 gives `done` 3 cycles after start.
  - Divide latency is unchanged.
- Undefined: every operation takes exactly W+2 cycles and the early-out logic is not present.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 34 cycles after start (macro undefined); `stall_request` high for cycles 0..33.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 ÷ 0 → LO=0xFFFFFFFF, HI=100, `div_by_zero`=1 for one cycle; DIV 0x80000000 ÷ -1 → LO=0x80000000, HI=0.
- Flush at cycle 10 of a DIV → no `done`, back in IDLE next cycle, HI/LO keep the previous result. A `start` asserted during CALC is ignored; the result matches the first operands.
- `rst` asserted at cycle 5 of a MULT → all outputs 0 next cycle; a new MULTU 6×7 then yields LO=42, HI=0.
- With `MULDIV_EARLY_OUT_EN`: MULTU 5×3 → `done` 4 cycles after start, LO=15; MULTU 9×0 → `done` after 3 cycles, HI=LO=0.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier runs out of set bits.
module muldiv_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  stall_request,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_result,
  output logic [DATA_WIDTH-1:0] lo_result,
  output logic                  div_by_zero
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic                 is_div;
  logic                 sign_lo;
  logic                 sign_hi;
  logic                 dbz;
  logic [W-1:0]         a_q;
  logic [W-1:0]         b_q;
  logic [2*W-1:0]       acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic           launch;
  logic           s1;
  logic           s2;
  logic [W-1:0]   abs1;
  logic [W-1:0]   abs2;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;
  logic [W:0]     div_rs;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] div_nxt;
  logic           calc_end;
  logic [2*W-1:0] prod_al;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo_f;
  logic [W-1:0]   rem_f;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  assign launch = (state == IDLE) && start && !flush;

  assign s1   = op[0] & operand_1[W-1];
  assign s2   = op[0] & operand_2[W-1];
  assign abs1 = s1 ? -operand_1 : operand_1;
  assign abs2 = s2 ? -operand_2 : operand_2;

  // multiplicand lands on the upper half, then everything shifts right
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (b_q[0] ? a_q : '0)};
  assign mul_nxt = {mul_sum, acc[W-1:1]};

  // partial remainder stays below the divisor, so W bits of the difference suffice
  assign div_rs   = {acc[2*W-1:W], acc[W-1]};
  assign div_ge   = div_rs >= {1'b0, b_q};
  assign div_diff = div_rs[W-1:0] - b_q;
  assign div_nxt  = {(div_ge ? div_diff : div_rs[W-1:0]), acc[W-2:0], div_ge};

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_WIDTH:0] shamt;
  assign calc_end = (cnt == LAST) || (!is_div && (b_q[W-1:1] == '0));
  assign shamt    = (CNT_WIDTH+1)'(W) - {1'b0, cnt};
  assign prod_al  = acc >> shamt;
`else
  assign calc_end = (cnt == LAST);
  assign prod_al  = acc;
`endif

  assign prod   = sign_lo ? -prod_al : prod_al;
  assign quo_f  = sign_lo ? -acc[W-1:0] : acc[W-1:0];
  assign rem_f  = sign_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign fix_hi = is_div ? rem_f : prod[2*W-1:W];
  assign fix_lo = is_div ? (dbz ? '1 : quo_f) : prod[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (launch) state_nxt = CALC;
      CALC: begin
        if (flush)         state_nxt = IDLE;
        else if (calc_end) state_nxt = FIX;
      end
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == CALC) || (state == FIX);
    done          = (state == DONE);
    stall_request = launch || busy;
    div_by_zero   = done && dbz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div    <= 1'b0;
      sign_lo   <= 1'b0;
      sign_hi   <= 1'b0;
      dbz       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      hi_result <= '0;
      lo_result <= '0;
    end else begin
      if (launch) begin
        is_div  <= op[1];
        sign_lo <= s1 ^ s2;
        sign_hi <= s1;
        dbz     <= op[1] && (operand_2 == '0);
        a_q     <= abs1;
        b_q     <= abs2;
        acc     <= op[1] ? {{W{1'b0}}, abs1} : '0;
        cnt     <= '0;
      end else if (state == CALC) begin
        acc <= is_div ? div_nxt : mul_nxt;
        cnt <= cnt + 1'b1;
        if (!is_div) b_q <= b_q >> 1;
      end
      if (state == FIX && !flush) begin
        hi_result <= fix_hi;
        lo_result <= fix_lo;
      end
    end
  end

endmodule
